// File: rtl/fifo_pkg.sv
// Shared constants and read-controller state type for the team's 16x8 synchronous FIFO.
package fifo_pkg;

  localparam int FIFO_DW    = 8;
  localparam int FIFO_DEPTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_FULL = 2'd2
  } rd_state_e;

  // Occupancy class after an edge, derived from buffered bytes and the pending read.
  function automatic rd_state_e rd_state(input logic [1:0] cnt, input logic inflight);
    if (cnt == 2'd2) begin
      return ST_FULL;
    end else if (cnt == 2'd1 || inflight) begin
      return ST_FILL;
    end
    return ST_IDLE;
  endfunction

endpackage

// File: rtl/fifo_rd_ctrl_if.sv
// FIFO read port plus downstream valid/ready byte stream seen by fifo_rd_ctrl.
interface fifo_rd_ctrl_if #(
  parameter int DW = fifo_pkg::FIFO_DW
);

  logic          fifo_rd;
  logic [DW-1:0] fifo_dout;
  logic          fifo_empty;
  logic          fifo_wr_acc;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic          m_last;
  logic [15:0]   rd_count;

  modport master (
    output fifo_rd,
    input  fifo_dout,
    input  fifo_empty,
    input  fifo_wr_acc,
    output m_data,
    output m_valid,
    input  m_ready,
    output m_last,
    output rd_count
  );

  modport slave (
    input  fifo_rd,
    output fifo_dout,
    output fifo_empty,
    output fifo_wr_acc,
    input  m_data,
    input  m_valid,
    output m_ready,
    input  m_last,
    input  rd_count
  );

endinterface

// File: rtl/fifo_skid_buf.sv
// Two-entry skid buffer: entry 0 is always the head, entry 1 the byte behind it.
module fifo_skid_buf
  import fifo_pkg::*;
#(
  parameter int DW = FIFO_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [DW-1:0] din_i,
  input  logic          pop_i,
  output logic [DW-1:0] head_o,
  output logic [1:0]    count_o
);

  logic [DW-1:0] ent0_q, ent0_d;
  logic [DW-1:0] ent1_q, ent1_d;
  logic [1:0]    cnt_q, cnt_d;

  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    cnt_d  = cnt_q;
    case ({push_i, pop_i})
      2'b10: begin
        if (cnt_q == 2'd0) begin
          ent0_d = din_i;
        end else begin
          ent1_d = din_i;
        end
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        ent0_d = ent1_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          ent0_d = din_i;
        end else begin
          ent0_d = ent1_q;
          ent1_d = din_i;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: the two data entries are reset so m_data reads 0 out of reset; cheap at this size.
      ent0_q <= '0;
      ent1_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      // NOTE: non-blocking assignments keep all flops updating from pre-edge values.
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
      cnt_q  <= cnt_d;
    end
  end

  assign head_o  = ent0_q;
  assign count_o = cnt_q;

  a_no_underflow : assert property (@(posedge clk) disable iff (!rst)
    !(pop_i && cnt_q == 2'd0));
  a_no_overflow : assert property (@(posedge clk) disable iff (!rst)
    !(push_i && !pop_i && cnt_q == 2'd2));

endmodule

// File: rtl/fifo_rd_ctrl.sv
// FIFO read-side controller: hides read latency and write priority behind a framed byte stream.
// Build option: define FIFO_RD_COUNT_EN to get a 16-bit delivered-byte counter on rd_count.
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int PKT_LEN = 4,
  parameter int DW      = FIFO_DW
) (
  input  logic           clk,
  input  logic           rst,
  fifo_rd_ctrl_if.master bus
);

  localparam logic [7:0] LAST_IDX = 8'(PKT_LEN - 1);

  rd_state_e     state_q, state_d;
  logic          inflight_q, inflight_d;
  logic [7:0]    pkt_cnt_q, pkt_cnt_d;
  logic [1:0]    buf_cnt, buf_cnt_nxt;
  logic [DW-1:0] head;
  logic          m_valid, pop, push;
  logic          rd_room, rd_req, rd_acc;

  assign m_valid = (buf_cnt != 2'd0);
  assign pop     = m_valid && bus.m_ready;
  assign push    = inflight_q;

  fifo_skid_buf #(.DW(DW)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .din_i   (bus.fifo_dout),
    .pop_i   (pop),
    .head_o  (head),
    .count_o (buf_cnt)
  );

  always_comb begin
    rd_room = 1'b0;
    // Room means buffered + pending - popping leaves a free slot at the next edge.
    case (state_q)
      ST_IDLE: rd_room = 1'b1;
      ST_FILL: rd_room = !(inflight_q && buf_cnt == 2'd1) || pop;
      ST_FULL: rd_room = !inflight_q && pop;
      default: rd_room = 1'b0;
    endcase

    rd_req      = rst && !bus.fifo_empty && rd_room;
    rd_acc      = rd_req && !bus.fifo_wr_acc;
    inflight_d  = rd_acc;
    buf_cnt_nxt = buf_cnt + {1'b0, push} - {1'b0, pop};
    state_d     = rd_state(buf_cnt_nxt, inflight_d);

    pkt_cnt_d = pkt_cnt_q;
    if (pop) begin
      pkt_cnt_d = (pkt_cnt_q == LAST_IDX) ? 8'd0 : pkt_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      inflight_q <= 1'b0;
      pkt_cnt_q  <= 8'd0;
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_d;
      pkt_cnt_q  <= pkt_cnt_d;
    end
  end

  assign bus.fifo_rd = rd_req;
  assign bus.m_data  = head;
  assign bus.m_valid = m_valid;
  assign bus.m_last  = m_valid && (pkt_cnt_q == LAST_IDX);

`ifdef FIFO_RD_COUNT_EN
  logic [15:0] rd_count_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_count_q <= 16'd0;
    end else if (pop) begin
      rd_count_q <= rd_count_q + 16'd1;
    end
  end

  assign bus.rd_count = rd_count_q;
`else
  assign bus.rd_count = 16'd0;
`endif

  a_state_consistent : assert property (@(posedge clk) disable iff (!rst)
    state_q == rd_state(buf_cnt, inflight_q));

endmodule

// File: doc/fifo_rd_ctrl.md
# fifo_rd_ctrl

Read-side controller for the team's 16-deep, 8-bit synchronous FIFO. It drives the FIFO read strobe and captures the FIFO's registered read data. It re-presents that data as a valid/ready byte stream with packet framing for downstream consumers. It sits between the FIFO's read port and any stream sink, and hides the FIFO's one-cycle read latency and write-priority arbitration.

## Interface
Parameters:
- PKT_LEN, 4, number of bytes per packet; `m_last` marks every PKT_LEN-th byte (legal 1..255)
- DW, 8, data width; must match FIFO width

Ports:
- clk  input  1  clock; all logic on posedge
- rst  input  1  reset; synchronous, active-low
- fifo_rd  output  1  read strobe to the FIFO
- fifo_dout  input  DW  FIFO registered read data
- fifo_empty  input  1  FIFO empty flag
- fifo_wr_acc  input  1  FIFO write accepted this cycle (wr && !full); a write blocks a same-cycle read
- m_data  output  DW  stream data
- m_valid  output  1  stream data valid
- m_ready  input  1  sink accepts when high with m_valid
- m_last  output  1  final byte of packet, qualified by m_valid
- rd_count  output  16  total bytes delivered downstream (config-dependent, see Configuration)

## Operation
- Read accepted at an edge iff fifo_rd && !fifo_empty && !fifo_wr_acc. An asserted but unaccepted read is treated as not issued.
- The 2-entry skid buffer holds captured bytes. `inflight` flags an accepted read whose data arrives next cycle.
- Issue rule: fifo_rd = !fifo_empty && (buf_cnt + inflight − pop < 2), where pop = m_valid && m_ready. The buffer never overflows.
- Capture: on the edge after an accepted read, fifo_dout is written to the buffer tail and inflight clears (or stays set if another read was accepted at the same edge).
- Output: m_data/m_valid reflect the buffer head. m_valid = (buf_cnt != 0). Push and pop at the same edge keep buf_cnt unchanged.
- Packet counter pkt_cnt (8-bit): increments on pop and wraps to 0 after PKT_LEN−1. m_last = m_valid && (pkt_cnt == PKT_LEN−1).
- States: IDLE (buf_cnt=0, !inflight), FILL (inflight or buf_cnt=1), FULL (buf_cnt=2). Transitions follow buf_cnt/inflight; no other state.

## Timing
- Reset (rst=0 at edge): fifo_rd=0, m_valid=0, m_data=0, m_last=0, buf_cnt=0, inflight=0, pkt_cnt=0, rd_count=0. Reset wins over all other events.
- Reset mid-operation drops the in-flight byte and the buffered bytes. A FIFO reset is expected concurrently.
- Latency: fifo_rd asserted in cycle N (accepted) → byte captured at edge N+1 → m_valid high in cycle N+2.
- Sustained throughput is 1 byte/cycle with m_ready held high and the FIFO non-empty and not being written.
- m_ready low with m_valid high: m_data and m_last hold stable. At most one further read is issued.
- fifo_wr_acc high: the read is blocked that cycle. fifo_rd may stay high and is retried next cycle with no data loss.
- fifo_empty rising while inflight: the inflight byte is still captured. No further reads are issued.
- PKT_LEN=1: m_last is high on every valid byte.

## Configuration
- FIFO_RD_COUNT_EN defined: rd_count is a 16-bit counter that increments on each pop and wraps 0xFFFF→0x0000.
- FIFO_RD_COUNT_EN undefined: rd_count is tied to 0 and no counter flops exist.

## Structure
- The shared package fifo_pkg holds the DW constant, the FIFO depth constant (16), and the state typedef (IDLE/FILL/FULL).
- One sub-module is natural: fifo_skid_buf (2-entry buffer with push/pop/count). The top holds issue logic, the packet counter and rd_count.

## Test plan
- Preload FIFO with 0x10..0x17, m_ready=1 → fifo_rd first accepted cycle N, m_valid from N+2, bytes 0x10..0x17 in order on consecutive cycles, m_last on 0x13 and 0x17.
- Preload 3 bytes, m_ready=0 for 10 cycles → exactly 2 reads accepted, m_data=first byte stable. Then m_ready=1 → all 3 bytes delivered, no loss or duplicate.
- Hold fifo_wr_acc=1 on alternate cycles while draining 0xA0..0xA7 → output still exactly 0xA0..0xA7 and each read is counted only when unblocked.
- FIFO with 1 byte 0x5A, fifo_empty rises after the accept → 0x5A delivered once, then m_valid=0 and fifo_rd=0.
- rst=0 asserted with buf_cnt=2 and inflight=1 → next cycle all outputs 0. After release, new bytes restart with pkt_cnt=0 (m_last on the 4th byte).
- FIFO_RD_COUNT_EN defined, stream 20 bytes → rd_count=20. Undefined → rd_count=0 throughout.
